twiddle_cmul: RTL and testbench

//  Twiddle-factor complex multiplier between the radix-4 butterfly stages of the 16-point FFT.

---
 rtl/fft_pkg.sv | 62 ++++++
 rtl/twiddle_cmul_mult.sv | 20 ++
 rtl/twiddle_cmul.sv | 138 +++++++++++++
 tb/tb_twiddle_cmul.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, FSM encoding and W16 twiddle ROM for the FFT datapath
package fft_pkg;

  localparam int N        = 8;
  localparam int FRAC     = N - 2;
  localparam int TW_IDX_W = 4;
  localparam int ACC_W    = 2 * N + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Real part of W16^k in Q1.(N-2): round(64*cos(2*pi*k/16))
  function automatic logic signed [N-1:0] tw_re(input logic [TW_IDX_W-1:0] k);
    case (k)
      4'd0:    tw_re = N'(64);
      4'd1:    tw_re = N'(59);
      4'd2:    tw_re = N'(45);
      4'd3:    tw_re = N'(24);
      4'd4:    tw_re = N'(0);
      4'd5:    tw_re = N'(-24);
      4'd6:    tw_re = N'(-45);
      4'd7:    tw_re = N'(-59);
      4'd8:    tw_re = N'(-64);
      4'd9:    tw_re = N'(-59);
      4'd10:   tw_re = N'(-45);
      4'd11:   tw_re = N'(-24);
      4'd12:   tw_re = N'(0);
      4'd13:   tw_re = N'(24);
      4'd14:   tw_re = N'(45);
      default: tw_re = N'(59);
    endcase
  endfunction

  // Imag part of W16^k in Q1.(N-2): round(-64*sin(2*pi*k/16))
  function automatic logic signed [N-1:0] tw_im(input logic [TW_IDX_W-1:0] k);
    case (k)
      4'd0:    tw_im = N'(0);
      4'd1:    tw_im = N'(-24);
      4'd2:    tw_im = N'(-45);
      4'd3:    tw_im = N'(-59);
      4'd4:    tw_im = N'(-64);
      4'd5:    tw_im = N'(-59);
      4'd6:    tw_im = N'(-45);
      4'd7:    tw_im = N'(-24);
      4'd8:    tw_im = N'(0);
      4'd9:    tw_im = N'(24);
      4'd10:   tw_im = N'(45);
      4'd11:   tw_im = N'(59);
      4'd12:   tw_im = N'(64);
      4'd13:   tw_im = N'(59);
      4'd14:   tw_im = N'(45);
      default: tw_im = N'(24);
    endcase
  endfunction

endpackage

// File: rtl/twiddle_cmul_mult.sv
// rtl/twiddle_cmul_mult.sv - combinational signed-by-unsigned multiplier shared by all four products
module twiddle_cmul_mult #(
  parameter int N = 8
) (
  input  logic signed [N-1:0]   x_i,
  input  logic        [N-1:0]   y_i,
  output logic signed [2*N-1:0] p_o
);

  logic signed [2*N-1:0] x_ext;
  logic signed [2*N-1:0] y_ext;

  // x is sign-extended, y is a magnitude so it is zero-extended; the product always fits 2N bits
  always_comb begin
    x_ext = {{N{x_i[N-1]}}, x_i};
    y_ext = {{N{1'b0}}, y_i};
    p_o   = x_ext * y_ext;
  end

endmodule

// File: rtl/twiddle_cmul.sv
// rtl/twiddle_cmul.sv - sample * W16^idx using one time-shared multiplier over four cycles
module twiddle_cmul
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_re,
  input  logic [N-1:0]        in_im,
  input  logic [TW_IDX_W-1:0] in_tw_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N:0]          out_re,
  output logic [N:0]          out_im
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** N) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** N));

  state_t                     state_q;
  logic signed [N-1:0]        ar_q, ai_q;
  logic [TW_IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0]    acc_re_q, acc_im_q;
  logic signed [ACC_W-1:0]    acc_re_d, acc_im_d;
  logic [N:0]                 out_re_q, out_im_q;
  logic                       out_valid_q;

  logic signed [N-1:0]        data_op, tw_op;
  logic                       data_neg;
  logic [N-1:0]               data_mag;
  logic signed [2*N-1:0]      prod_mag, prod_s;
  logic signed [ACC_W-1:0]    prod_ext;

  // Floor-shifted accumulator clamped to the N+1 bit output range
  function automatic logic [N:0] sat_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> FRAC;
    if (s > SAT_HI)      sat_shift = SAT_HI[N:0];
    else if (s < SAT_LO) sat_shift = SAT_LO[N:0];
    else                 sat_shift = s[N:0];
  endfunction

  twiddle_cmul_mult #(.N(N)) u_mult (
    .x_i (tw_op),
    .y_i (data_mag),
    .p_o (prod_mag)
  );

  // Pick this cycle's data/twiddle pair and restore the data sign on the magnitude product
  always_comb begin
    data_op = ar_q;
    tw_op   = tw_re(idx_q);
    case (state_q)
      S_M1:    begin data_op = ai_q; tw_op = tw_im(idx_q); end
      S_M2:    begin data_op = ar_q; tw_op = tw_im(idx_q); end
      S_M3:    begin data_op = ai_q; tw_op = tw_re(idx_q); end
      default: ;
    endcase
    data_neg = data_op[N-1];
    data_mag = data_neg ? N'(-data_op) : N'(data_op);
    prod_s   = data_neg ? -prod_mag : prod_mag;
    prod_ext = {prod_s[2*N-1], prod_s};
  end

  // Accumulator next values: re gets +ar*wr -ai*wi, im gets +ar*wi +ai*wr
  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    case (state_q)
      S_M0:    acc_re_d = acc_re_q + prod_ext;
      S_M1:    acc_re_d = acc_re_q - prod_ext;
      S_M2:    acc_im_d = acc_im_q + prod_ext;
      S_M3:    acc_im_d = acc_im_q + prod_ext;
      default: ;
    endcase
  end

  // Control FSM with operand capture, accumulation and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ar_q        <= '0;
      ai_q        <= '0;
      idx_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ar_q     <= in_re;
            ai_q     <= in_im;
            idx_q    <= in_tw_idx;
            acc_re_q <= '0;
            acc_im_q <= '0;
            state_q  <= S_M0;
          end
        end
        S_M0: begin
          acc_re_q <= acc_re_d;
          state_q  <= S_M1;
        end
        S_M1: begin
          acc_re_q <= acc_re_d;
          state_q  <= S_M2;
        end
        S_M2: begin
          acc_im_q <= acc_im_d;
          state_q  <= S_M3;
        end
        S_M3: begin
          acc_im_q    <= acc_im_d;
          out_re_q    <= sat_shift(acc_re_d);
          out_im_q    <= sat_shift(acc_im_d);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_twiddle_cmul.sv
// tb/tb_twiddle_cmul.sv - randomized and directed bench for twiddle_cmul against an arithmetic model
module tb_twiddle_cmul;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_re, in_im;
  logic [3:0] in_tw_idx;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_re, out_im;

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;

  twiddle_cmul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_tw_idx (in_tw_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && out_valid && out_ready) xfer_cnt++;

  // sample * W16^k with twiddles from trig, floor shift by 6, clamp to 9 bits
  function automatic void model(input int ar, input int ai, input int k, output int re, output int im);
    real ang;
    int wr, wi;
    ang = 2.0 * 3.14159265358979 * k / 16.0;
    wr = int'(64.0 * $cos(ang));
    wi = -int'(64.0 * $sin(ang));
    re = (ar * wr - ai * wi) >>> 6;
    im = (ar * wi + ai * wr) >>> 6;
    if (re > 255) re = 255;
    if (re < -256) re = -256;
    if (im > 255) im = 255;
    if (im < -256) im = -256;
  endfunction

  // Drive one sample, scramble inputs after accept, return result and cycles from accept to out_valid
  task automatic transact(input int ar, input int ai, input int k, output int ore, output int oim, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_re = 8'(ar); in_im = 8'(ai); in_tw_idx = 4'(k);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_re = 8'($urandom); in_im = 8'($urandom); in_tw_idx = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    ore = $signed(out_re);
    oim = $signed(out_im);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_re !== 9'd0) begin bad++; $display("FAIL reset_out_re got=%0d want=0", out_re); end
    total++; if (out_im !== 9'd0) begin bad++; $display("FAIL reset_out_im got=%0d want=0", out_im); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int re, im, lat;
    transact(100, -50, 0, re, im, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL id_latency got=%0d want=5", lat); end
    total++; if (re !== 100) begin bad++; $display("FAIL id_re got=%0d want=100", re); end
    total++; if (im !== -50) begin bad++; $display("FAIL id_im got=%0d want=-50", im); end
    transact(100, -50, 4, re, im, lat);
    total++; if (re !== -50 || im !== -100) begin bad++; $display("FAIL minus_j got=(%0d,%0d) want=(-50,-100)", re, im); end
    transact(64, 0, 2, re, im, lat);
    total++; if (re !== 45 || im !== -45) begin bad++; $display("FAIL idx2 got=(%0d,%0d) want=(45,-45)", re, im); end
    total++; if (lat !== 5) begin bad++; $display("FAIL idx2_latency got=%0d want=5", lat); end
    transact(-128, -128, 8, re, im, lat);
    total++; if (re !== 128 || im !== 128) begin bad++; $display("FAIL full_range got=(%0d,%0d) want=(128,128)", re, im); end
  endtask

  task automatic test_floor;
    int re, im, lat;
    transact(1, 0, 1, re, im, lat);
    total++; if (re !== 0 || im !== -1) begin bad++; $display("FAIL floor_pos got=(%0d,%0d) want=(0,-1)", re, im); end
    transact(-1, 0, 1, re, im, lat);
    total++; if (re !== -1 || im !== 0) begin bad++; $display("FAIL floor_neg got=(%0d,%0d) want=(-1,0)", re, im); end
  endtask

  task automatic test_random;
    int ar, ai, k, re, im, mre, mim, lat;
    for (int i = 0; i < 40; i++) begin
      ar = int'($urandom_range(0, 255)) - 128;
      ai = int'($urandom_range(0, 255)) - 128;
      k  = (i < 16) ? i : int'($urandom_range(0, 15));
      model(ar, ai, k, mre, mim);
      transact(ar, ai, k, re, im, lat);
      total++; if (re !== mre || im !== mim || lat !== 5)
        begin bad++; $display("FAIL rand in=(%0d,%0d) k=%0d got=(%0d,%0d) lat=%0d want=(%0d,%0d) lat=5", ar, ai, k, re, im, lat, mre, mim); end
    end
  endtask

  task automatic test_backpressure;
    int are, aim, bre, bim, lat, x0;
    model(37, -90, 3, are, aim);
    model(-77, 55, 6, bre, bim);
    out_ready = 1'b0;
    in_valid = 1'b1; in_re = 8'(37); in_im = 8'(-90); in_tw_idx = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_re = 8'(-77); in_im = 8'(55); in_tw_idx = 4'd6;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat !== 5) begin bad++; $display("FAIL bp_latency got=%0d want=5", lat); end
    x0 = xfer_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || $signed(out_re) !== are || $signed(out_im) !== aim)
        begin bad++; $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b (%0d,%0d) want v=1 rdy=0 (%0d,%0d)", c, out_valid, in_ready, $signed(out_re), $signed(out_im), are, aim); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    total++; if (xfer_cnt !== x0 + 1) begin bad++; $display("FAIL bp_one_xfer got=%0d want=%0d", xfer_cnt - x0, 1); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got rdy=%b want=0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat !== 5 || $signed(out_re) !== bre || $signed(out_im) !== bim)
      begin bad++; $display("FAIL bp_second got=(%0d,%0d) lat=%0d want=(%0d,%0d) lat=5", $signed(out_re), $signed(out_im), lat, bre, bim); end
    @(posedge clk);
    @(negedge clk);
    total++; if (xfer_cnt !== x0 + 2) begin bad++; $display("FAIL bp_xfer_total got=%0d want=%0d", xfer_cnt - x0, 2); end
  endtask

  task automatic test_reset_mid;
    int re, im, mre, mim, lat, seen;
    in_valid = 1'b1; in_re = 8'(120); in_im = 8'(-33); in_tw_idx = 4'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    total++; if (out_re !== 9'd0 || out_im !== 9'd0) begin bad++; $display("FAIL mid_rst_out got=(%0d,%0d) want=(0,0)", out_re, out_im); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_pulse got=%0d want=0", seen); end
    model(-90, 17, 11, mre, mim);
    transact(-90, 17, 11, re, im, lat);
    total++; if (re !== mre || im !== mim || lat !== 5)
      begin bad++; $display("FAIL mid_next got=(%0d,%0d) lat=%0d want=(%0d,%0d) lat=5", re, im, lat, mre, mim); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_re = '0; in_im = '0; in_tw_idx = '0;
    test_reset();
    test_directed();
    test_floor();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
